// File: rtl/riscv_m_pkg.sv
// Shared types for the RV32M/RV64M multiply/divide unit: funct3 encodings,
// FSM states and operand signedness helpers.
package riscv_m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } md_state_t;

    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Two's-complement conditional negation: o_out = i_neg ? -i_in : i_in.
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_in,
    input  logic         i_neg,
    output logic [W-1:0] o_out
);

    assign o_out = i_neg ? -i_in : i_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fix applied on entry to DONE.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      OpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    md_state_t             r_state;
    muldiv_op_t            r_op;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [XLEN-1:0]       r_a;
    logic [2*XLEN-1:0]     r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_result;
    logic                  r_done;

    muldiv_op_t            w_op;
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_div0;
    logic                  w_ovf;
    logic [XLEN-1:0]       w_fast_res;
    logic [XLEN:0]         w_mul_sum;
    logic [2*XLEN-1:0]     w_mul_nxt;
    logic [XLEN:0]         w_div_sh;
    logic [XLEN:0]         w_div_diff;
    logic [2*XLEN-1:0]     w_div_nxt;
    logic [2*XLEN-1:0]     w_fix_in;
    logic                  w_fix_neg;
    logic [2*XLEN-1:0]     w_fix_out;
    logic [XLEN-1:0]       w_fix_res;

    assign w_op     = muldiv_op_t'(OpE);
    assign w_sign_a = is_signed_a(w_op) & SrcAE[XLEN-1];
    assign w_sign_b = is_signed_b(w_op) & SrcBE[XLEN-1];

    cond_negate #(.W(XLEN)) u_mag_a (.i_in(SrcAE), .i_neg(w_sign_a), .o_out(w_mag_a));
    cond_negate #(.W(XLEN)) u_mag_b (.i_in(SrcBE), .i_neg(w_sign_b), .o_out(w_mag_b));

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign w_div0     = (SrcBE == '0);
    assign w_ovf      = OpE[2] & ~OpE[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcBE);
    assign w_fast_res = w_div0 ? (OpE[1] ? SrcAE : '1) : (OpE[1] ? '0 : SrcAE);

    // Multiply: acc = {partial high, multiplier}; add into the top, shift right.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
    assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_a};
    assign w_div_nxt  = w_div_diff[XLEN]
                      ? {w_div_sh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                      : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    always_comb begin
        w_fix_in  = '0;
        w_fix_neg = 1'b0;
        if (r_state == S_MUL) begin
            w_fix_in  = w_mul_nxt;
            w_fix_neg = r_sign_a ^ r_sign_b;
        end else if (r_op[1]) begin
            w_fix_in[XLEN-1:0] = w_div_nxt[2*XLEN-1:XLEN];
            w_fix_neg          = r_sign_a;
        end else begin
            w_fix_in[XLEN-1:0] = w_div_nxt[XLEN-1:0];
            w_fix_neg          = r_sign_a ^ r_sign_b;
        end
    end

    cond_negate #(.W(2*XLEN)) u_fix (.i_in(w_fix_in), .i_neg(w_fix_neg), .o_out(w_fix_out));

    assign w_fix_res = ((r_state == S_MUL) && (r_op != OP_MUL))
                     ? w_fix_out[2*XLEN-1:XLEN] : w_fix_out[XLEN-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (StartE && !FlushE) begin
                        r_op     <= w_op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_cnt    <= CNT_W'(XLEN);
                        if (!OpE[2]) begin
                            r_a     <= w_mag_a;
                            r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                            r_state <= S_MUL;
                        end else if (w_div0 || w_ovf) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_a     <= w_mag_b;
                            r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= (r_state == S_MUL) ? w_mul_nxt : w_div_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_result <= w_fix_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BusyE   = (StartE && (r_state == S_IDLE) && !FlushE) ||
                     (r_state == S_MUL) || (r_state == S_DIV);
    assign DoneE   = r_done;
    assign ResultE = r_result;

endmodule
